axi_lite_dm_cache: RTL and testbench
====================================

// Module: axi_lite_dm_cache
// PURPOSE
//  Parametrised direct-mapped, write-through, no-write-allocate cache placed between the core's AXI-Lite
//  memory port (s_*) and the memory/bus side (m_*). Generalises the fixed single-word cache:
//  configurable set count and multi-word lines refilled by a sequential AXI-Lite read burst.
//  Handles one transaction at a time. Data width is 32 bits; address width is 32 bits.
// PARAMETERS
//  INDEX_BITS  8  log2(number of sets); legal range 1..12.
//  LINE_WORDS  4  32-bit words per line; power of two, 1..16. OFS=log2(LINE_WORDS).
//  TAG_BITS = 30-INDEX_BITS-OFS (derived localparam). Address split: [31:32-TAG_BITS] tag | index | word | [1:0] byte.
// PORTS
//  clk         in   1   clock.
//  rstn        in   1   asynchronous active-low reset.
//  s_ar{addr,prot,valid}/s_arready   in/in/in/out  32/3/1/1  slave read address channel.
//  s_r{data,resp,valid}/s_rready     out/out/out/in 32/2/1/1  slave read data channel.
//  s_aw{addr,prot,valid}/s_awready   in/in/in/out  32/3/1/1  slave write address channel.
//  s_w{data,strb,valid}/s_wready     in/in/in/out  32/4/1/1  slave write data channel.
//  s_b{resp,valid}/s_bready          out/out/in    2/1/1     slave write response channel.
//  m_ar*, m_r*, m_aw*, m_w*, m_b*    mirror of the s_* set, opposite directions; master side.
//  hit_cnt     out  32  read-hit count (see CONFIGURATION).
//  miss_cnt    out  32  read-miss count (see CONFIGURATION).
// BEHAVIOUR
//  Reset (rstn=0, async): all valid bits cleared, FSM->IDLE; every *valid/*ready output 0; m_*addr, m_wdata,
//   m_wstrb, m_*prot, s_rdata and s_*resp are 0; counters are 0. A reset mid-transaction abandons it with no
//   response. The data array has no reset.
//  FSM: IDLE -> LOOKUP -> (RESP | REF_AR <-> REF_R -> RESP) for reads; IDLE -> WR_REQ -> WR_B -> BRESP for writes.
//  IDLE: s_arready=1 and s_awready=s_wready=1 only in IDLE. Writes are accepted only when s_awvalid and s_wvalid
//   are both 1 in the same cycle. If read and write are both valid, the read wins and the write is held.
//  Read hit: AR handshake at cycle t; LOOKUP at t+1; s_rvalid=1 at t+2 with s_rresp=2'b00.
//   s_rvalid holds, with stable data, until s_rready; then IDLE.
//  Read miss: refill words 0..LINE_WORDS-1 of the line in ascending order, one m_ar/m_r pair per word;
//   m_araddr={tag,index,word,2'b00}; m_arprot=captured s_arprot.
//   m_arvalid holds until m_arready; m_rready=1 in REF_R. Then s_rdata=requested word.
//   s_rresp = worst (max) m_rresp seen during the refill.
//   If any m_rresp!=0, the line is left invalid and the refilled words are not trusted.
//  Write: no lookup stall. WR_REQ drives m_awvalid and m_wvalid together with captured addr/data/strb/prot.
//   Each valid drops independently on its own ready. WR_B sets m_bready=1.
//   On hit, the cached word is byte-merged by wstrb in the cycle m_bvalid&&m_bresp==0.
//   On miss, no allocation. s_bresp=m_bresp; s_bvalid holds until s_bready.
//  Hit: valid[index] && tag_mem[index]==addr tag, evaluated in LOOKUP or WR_REQ entry.
//   A write to the line being refilled cannot occur (single outstanding).
//  Unaligned addr[1:0] is ignored (forced to 0 on m_*addr).
// CONFIGURATION
//  CACHE_STATS_EN defined: hit_cnt/miss_cnt increment once per read at LOOKUP, saturating at 32'hFFFF_FFFF.
//  CACHE_STATS_EN undefined: hit_cnt=miss_cnt=0 constantly; no counter flops.
// TESTING (INDEX_BITS=8, LINE_WORDS=4, CACHE_STATS_EN defined, memory model returns addr^32'hA5A5_0000)
//  1. Read 0x0000_1004 cold -> 4 m_ar at 0x1000,0x1004,0x1008,0x100C;
//     s_rdata=0xA5A5_1004, s_rresp=0; miss_cnt=1.
//  2. Then read 0x0000_100C -> no m_arvalid; s_rvalid exactly 2 cycles after the AR handshake;
//     data 0xA5A5_100C; hit_cnt=1.
//  3. Write 0x0000_1008, wdata=0x1122_3344, wstrb=4'b0011, bresp=0 -> one m_aw/m_w; s_bresp=0;
//     reread 0x1008 hits with data 0xA5A5_3344.
//  4. Read 0x0010_1000 (same index, new tag) -> refill evicts; reread of 0x1004 misses again, miss_cnt=3.
//  5. Refill with m_rresp=2'b10 on word 2 -> s_rresp=2'b10; an immediate reread of the same addr misses (line invalid).
//  6. s_arvalid&&s_awvalid same cycle -> read handled first, write accepted on return to IDLE.
//     Separately, rstn pulsed low during REF_R -> all valids 0, counters 0, next read misses.

Source files
------------

// File: rtl/axi_lite_dm_cache.sv
// Direct-mapped write-through, no-write-allocate AXI-Lite cache with multi-word line refill.
// Optional read hit/miss counters are built in when CACHE_STATS_EN is defined.
module axi_lite_dm_cache #(
   parameter int INDEX_BITS = 8,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] s_araddr,
   input  logic [2:0]  s_arprot,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [31:0] s_awaddr,
   input  logic [2:0]  s_awprot,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   output logic [31:0] m_araddr,
   output logic [2:0]  m_arprot,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [31:0] m_awaddr,
   output logic [2:0]  m_awprot,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int OFS      = $clog2(LINE_WORDS);
   localparam int TAG_BITS = 30 - INDEX_BITS - OFS;
   localparam int SETS     = 1 << INDEX_BITS;
   localparam int AW       = INDEX_BITS + OFS;
   localparam int WW       = (OFS > 0) ? OFS : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, REF_AR, REF_R, RESP, WR_REQ, WR_B, BRESP} state_t;
   state_t state, state_nx;

   logic                run;
   logic [31:0]         addr_q, wdata_q, rdata_q;
   logic [2:0]          prot_q;
   logic [3:0]          wstrb_q;
   logic [WW-1:0]       word_q;
   logic [1:0]          rresp_q, bresp_q;
   logic                wr_hit_q, aw_pend, w_pend;
   logic [SETS-1:0]     valid_mem;
   logic [TAG_BITS-1:0] tag_mem  [SETS];
   logic [31:0]         data_mem [SETS*LINE_WORDS];

   logic [INDEX_BITS-1:0] idx_q, aw_idx;
   logic [TAG_BITS-1:0]   tag_q, aw_tag;
   logic [AW-1:0]         req_widx, fill_widx;
   logic [WW-1:0]         req_word;
   logic [1:0]            rresp_mx;
   logic [31:0]           merged;
   logic                  lookup_hit, last_word, ar_go, wr_go;

   assign idx_q      = addr_q[2+OFS +: INDEX_BITS];
   assign tag_q      = addr_q[31 -: TAG_BITS];
   assign aw_idx     = s_awaddr[2+OFS +: INDEX_BITS];
   assign aw_tag     = s_awaddr[31 -: TAG_BITS];
   assign req_widx   = addr_q[2 +: AW];
   assign req_word   = WW'(addr_q[31:2]) & WW'(LINE_WORDS - 1);
   assign fill_widx  = (AW'(idx_q) << OFS) | AW'(word_q);
   assign lookup_hit = valid_mem[idx_q] && (tag_mem[idx_q] == tag_q);
   assign last_word  = (word_q == WW'(LINE_WORDS - 1));
   assign rresp_mx   = (m_rresp > rresp_q) ? m_rresp : rresp_q;

   // Reads take priority; a write needs both AW and W present together.
   assign ar_go     = (state == IDLE) && run && s_arvalid;
   assign wr_go     = (state == IDLE) && run && !s_arvalid && s_awvalid && s_wvalid;
   assign s_awready = wr_go;
   assign s_wready  = wr_go;

   assign m_araddr = (addr_q & ~32'(LINE_WORDS*4 - 1)) | (32'(word_q) << 2);
   assign m_arprot = prot_q;
   assign m_awaddr = addr_q;
   assign m_awprot = prot_q;
   assign m_wdata  = wdata_q;
   assign m_wstrb  = wstrb_q;
   assign s_rdata  = rdata_q;
   assign s_rresp  = rresp_q;
   assign s_bresp  = bresp_q;

   always_comb begin
      merged = data_mem[req_widx];
      for (int b = 0; b < 4; b++)
         if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      s_bvalid  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      case (state)
         IDLE: begin
            s_arready = run;
            if (ar_go)      state_nx = LOOKUP;
            else if (wr_go) state_nx = WR_REQ;
         end
         LOOKUP: state_nx = lookup_hit ? RESP : REF_AR;
         REF_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) state_nx = REF_R;
         end
         REF_R: begin
            m_rready = 1'b1;
            if (m_rvalid) state_nx = last_word ? RESP : REF_AR;
         end
         RESP: begin
            s_rvalid = 1'b1;
            if (s_rready) state_nx = IDLE;
         end
         WR_REQ: begin
            m_awvalid = aw_pend;
            m_wvalid  = w_pend;
            if ((!aw_pend || m_awready) && (!w_pend || m_wready)) state_nx = WR_B;
         end
         WR_B: begin
            m_bready = 1'b1;
            if (m_bvalid) state_nx = BRESP;
         end
         BRESP: begin
            s_bvalid = 1'b1;
            if (s_bready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // run keeps every ready low while reset is asserted and for the first cycle after.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run       <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         prot_q    <= '0;
         wstrb_q   <= '0;
         word_q    <= '0;
         rresp_q   <= '0;
         bresp_q   <= '0;
         wr_hit_q  <= 1'b0;
         aw_pend   <= 1'b0;
         w_pend    <= 1'b0;
         valid_mem <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            IDLE: begin
               if (ar_go) begin
                  addr_q <= s_araddr & ~32'h3;
                  prot_q <= s_arprot;
               end else if (wr_go) begin
                  addr_q   <= s_awaddr & ~32'h3;
                  prot_q   <= s_awprot;
                  wdata_q  <= s_wdata;
                  wstrb_q  <= s_wstrb;
                  aw_pend  <= 1'b1;
                  w_pend   <= 1'b1;
                  wr_hit_q <= valid_mem[aw_idx] && (tag_mem[aw_idx] == aw_tag);
               end
            end
            LOOKUP: begin
               word_q  <= '0;
               rresp_q <= '0;
               if (lookup_hit) rdata_q <= data_mem[req_widx];
               else            valid_mem[idx_q] <= 1'b0;
            end
            REF_R: begin
               if (m_rvalid) begin
                  rresp_q <= rresp_mx;
                  if (word_q == req_word) rdata_q <= m_rdata;
                  if (last_word) valid_mem[idx_q] <= (rresp_mx == 2'b00);
                  else           word_q <= word_q + 1'b1;
               end
            end
            WR_REQ: begin
               if (m_awready) aw_pend <= 1'b0;
               if (m_wready)  w_pend  <= 1'b0;
            end
            WR_B: if (m_bvalid) bresp_q <= m_bresp;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REF_R && m_rvalid) begin
         data_mem[fill_widx] <= m_rdata;
         if (last_word) tag_mem[idx_q] <= tag_q;
      end
      if (state == WR_B && m_bvalid && m_bresp == 2'b00 && wr_hit_q)
         data_mem[req_widx] <= merged;
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == LOOKUP) begin
         if (lookup_hit && hit_cnt != 32'hFFFF_FFFF)        hit_cnt  <= hit_cnt + 32'd1;
         else if (!lookup_hit && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_axi_lite_dm_cache.sv
// Randomised bench for axi_lite_dm_cache against a line-level cache model and a memory returning addr^A5A5_0000.
module tb_axi_lite_dm_cache;
   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic        clk = 1'b0, rstn = 1'b0;
   logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
   logic [2:0]  s_arprot = '0, s_awprot = '0;
   logic        s_arvalid = 0, s_rready = 0, s_awvalid = 0, s_wvalid = 0, s_bready = 0;
   logic [3:0]  s_wstrb = '0;
   logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   logic [31:0] m_araddr, m_awaddr, m_wdata;
   logic [2:0]  m_arprot, m_awprot;
   logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [3:0]  m_wstrb;
   logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
   logic [31:0] m_rdata = '0;
   logic [1:0]  m_rresp = '0, m_bresp = '0;
   logic [31:0] hit_cnt, miss_cnt;

   always #5 clk = ~clk;

   axi_lite_dm_cache #(.INDEX_BITS(8), .LINE_WORDS(4)) dut (
      .clk(clk), .rstn(rstn),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Cache model: one entry per set, whole-line granularity.
   bit          mv [256];
   logic [19:0] mt [256];
   logic [31:0] md [256][4];
   int unsigned m_hit = 0, m_miss = 0;
   logic [31:0] inj_addr = 32'hFFFF_FFFF;
   logic [1:0]  inj_resp = 2'b00;
   logic [31:0] exp_rdata = '0;
   logic [1:0]  exp_rresp = '0, exp_bresp = '0, wr_bresp = '0;

   logic [31:0] ar_q[$], aw_q[$], wd_q[$];
   logic [2:0]  arprot_q[$], awprot_q[$];
   logic [3:0]  ws_q[$];

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mv[i] = 1'b0;
      m_hit = 0;
      m_miss = 0;
   endtask

   task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                             output bit hit);
      int idx;
      logic [31:0] wa;
      logic [1:0] rr;
      idx = int'(a[11:4]);
      hit = mv[idx] && (mt[idx] == a[31:12]);
      r = 2'b00;
      if (hit) m_hit++;
      else begin
         m_miss++;
         for (int i = 0; i < 4; i++) begin
            wa = {a[31:4], 4'b0000} + 32'(4 * i);
            rr = (wa == inj_addr) ? inj_resp : 2'b00;
            if (rr > r) r = rr;
            md[idx][i] = wa ^ MAGIC;
         end
         mv[idx] = (r == 2'b00);
         mt[idx] = a[31:12];
      end
      d = md[idx][a[3:2]];
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] br);
      int idx;
      idx = int'(a[11:4]);
      if (mv[idx] && mt[idx] == a[31:12] && br == 2'b00)
         for (int b = 0; b < 4; b++)
            if (s[b]) md[idx][a[3:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   // Memory-side read responder with random ready/valid delays.
   bit pend = 0, r_fire = 0;
   logic [31:0] paddr = '0;
   initial forever begin
      @(negedge clk);
      if (!rstn) begin
         m_arready = 0; m_rvalid = 0; m_rresp = 2'b00; pend = 0; r_fire = 0;
      end else begin
         if (r_fire) begin
            m_rvalid = 0;
            r_fire = 0;
         end else if (pend && !m_rvalid && $urandom_range(0, 1) == 1) begin
            m_rvalid = 1;
            m_rdata = paddr ^ MAGIC;
            m_rresp = (paddr == inj_addr) ? inj_resp : 2'b00;
            pend = 0;
         end
         m_arready = m_arvalid && !pend && !m_rvalid && ($urandom_range(0, 2) != 0);
         if (m_arready) begin
            paddr = m_araddr;
            ar_q.push_back(m_araddr);
            arprot_q.push_back(m_arprot);
            pend = 1;
         end
         r_fire = m_rvalid && m_rready;
      end
   end

   // Memory-side write responder; B is raised only after both AW and W have been taken.
   bit got_aw = 0, got_w = 0, b_fire = 0;
   initial forever begin
      @(negedge clk);
      if (!rstn) begin
         m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
         got_aw = 0; got_w = 0; b_fire = 0;
      end else begin
         if (b_fire) begin
            m_bvalid = 0; b_fire = 0; got_aw = 0; got_w = 0;
         end else if (got_aw && got_w && !m_bvalid && $urandom_range(0, 1) == 1) begin
            m_bvalid = 1;
            m_bresp = wr_bresp;
         end
         m_awready = m_awvalid && !got_aw && ($urandom_range(0, 1) == 1);
         if (m_awready) begin
            aw_q.push_back(m_awaddr); awprot_q.push_back(m_awprot); got_aw = 1;
         end
         m_wready = m_wvalid && !got_w && ($urandom_range(0, 1) == 1);
         if (m_wready) begin
            wd_q.push_back(m_wdata); ws_q.push_back(m_wstrb); got_w = 1;
         end
         b_fire = m_bvalid && m_bready;
      end
   end

   // Response channels are compared against the model on every cycle they are valid.
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (s_rvalid) begin
            chk("s_rdata", s_rdata, exp_rdata);
            chk("s_rresp", 32'(s_rresp), 32'(exp_rresp));
         end
         if (s_bvalid) chk("s_bresp", 32'(s_bresp), 32'(exp_bresp));
      end
   end

   task automatic chk_counters(input string tag);
`ifdef CACHE_STATS_EN
      chk({tag, "_hit_cnt"}, hit_cnt, m_hit);
      chk({tag, "_miss_cnt"}, miss_cnt, m_miss);
`else
      chk({tag, "_hit_cnt"}, hit_cnt, 32'd0);
      chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
`endif
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valids"}, 32'({s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid}), 32'd0);
      chk({tag, "_readies"}, 32'({s_arready, s_awready, s_wready, m_rready, m_bready}), 32'd0);
      chk({tag, "_m_araddr"}, m_araddr, 32'd0);
      chk({tag, "_m_awaddr"}, m_awaddr, 32'd0);
      chk({tag, "_m_wdata"}, m_wdata, 32'd0);
      chk({tag, "_misc"}, 32'({m_wstrb, m_arprot, m_awprot, s_rresp, s_bresp}), 32'd0);
      chk({tag, "_s_rdata"}, s_rdata, 32'd0);
      chk({tag, "_hit_cnt"}, hit_cnt, 32'd0);
      chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
   endtask

   task automatic wait_ar_accept();
      int n = 0;
      while (!s_arready && n < 50) begin @(negedge clk); n++; end
      chk("ar_accept", 32'(n < 50), 32'd1);
   endtask

   task automatic finish_read(input bit hit, input logic [31:0] a, input logic [2:0] prot);
      int lat = 1;
      while (!s_rvalid && lat < 300) begin @(negedge clk); lat++; end
      chk("rvalid_seen", 32'(s_rvalid), 32'd1);
      if (hit) begin
         chk("hit_latency", 32'(lat), 32'd2);
         chk("hit_no_ar", 32'(ar_q.size()), 32'd0);
      end else begin
         chk("refill_ar_count", 32'(ar_q.size()), 32'd4);
         foreach (ar_q[i]) begin
            chk("refill_araddr", ar_q[i], {a[31:4], 4'b0000} + 32'(4 * i));
            chk("refill_arprot", 32'(arprot_q[i]), 32'(prot));
         end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("rvalid_hold", 32'(s_rvalid), 32'd1);
      s_rready = 1;
      @(negedge clk);
      s_rready = 0;
      chk_counters("rd");
   endtask

   task automatic rd(input logic [31:0] a, input logic [2:0] prot, output bit hit);
      logic [31:0] d;
      logic [1:0] r;
      model_read(a, d, r, hit);
      exp_rdata = d;
      exp_rresp = r;
      ar_q.delete(); arprot_q.delete();
      @(negedge clk);
      s_araddr = a; s_arprot = prot; s_arvalid = 1;
      wait_ar_accept();
      @(negedge clk);
      s_arvalid = 0;
      finish_read(hit, a, prot);
   endtask

   task automatic wait_b_and_check(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input logic [2:0] prot);
      int n = 0;
      while (!s_bvalid && n < 300) begin @(negedge clk); n++; end
      chk("bvalid_seen", 32'(s_bvalid), 32'd1);
      chk("m_aw_count", 32'(aw_q.size()), 32'd1);
      chk("m_w_count", 32'(wd_q.size()), 32'd1);
      if (aw_q.size() == 1 && wd_q.size() == 1) begin
         chk("m_awaddr", aw_q[0], a & ~32'h3);
         chk("m_awprot", 32'(awprot_q[0]), 32'(prot));
         chk("m_wdata", wd_q[0], d);
         chk("m_wstrb", 32'(ws_q[0]), 32'(s));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s_bready = 1;
      @(negedge clk);
      s_bready = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] prot, input logic [1:0] br);
      int n = 0;
      model_write(a, d, s, br);
      exp_bresp = br;
      wr_bresp = br;
      aw_q.delete(); awprot_q.delete(); wd_q.delete(); ws_q.delete();
      @(negedge clk);
      s_awaddr = a; s_awprot = prot; s_wdata = d; s_wstrb = s;
      s_awvalid = 1; s_wvalid = 1;
      #1;
      while (!s_awready && n < 50) begin @(negedge clk); #1; n++; end
      chk("aw_accept", 32'(n < 50), 32'd1);
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      wait_b_and_check(a, d, s, prot);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      logic [31:0] a, d;
      logic [1:0] r;
      int n;
      model_clear();
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rstn = 1;
      repeat (2) @(negedge clk);

      // Cold miss refills the whole line in ascending order.
      rd(32'h0000_1004, 3'b010, hit);
      chk("t1_miss", 32'(hit), 32'd0);
      chk("t1_model_data", exp_rdata, 32'hA5A5_1004);
      chk("t1_ar0", ar_q.size() > 0 ? ar_q[0] : 32'hDEAD_DEAD, 32'h0000_1000);
      chk("t1_ar3", ar_q.size() > 3 ? ar_q[3] : 32'hDEAD_DEAD, 32'h0000_100C);
      chk("t1_model_miss", m_miss, 32'd1);

      rd(32'h0000_100C, 3'b000, hit);
      chk("t2_hit", 32'(hit), 32'd1);
      chk("t2_model_data", exp_rdata, 32'hA5A5_100C);
      chk("t2_model_hit", m_hit, 32'd1);

      wr(32'h0000_1008, 32'h1122_3344, 4'b0011, 3'b001, 2'b00);
      rd(32'h0000_1008, 3'b000, hit);
      chk("t3_hit", 32'(hit), 32'd1);
      chk("t3_model_data", exp_rdata, 32'hA5A5_3344);

      rd(32'h0010_1000, 3'b000, hit);
      chk("t4_evict_miss", 32'(hit), 32'd0);
      rd(32'h0000_1004, 3'b000, hit);
      chk("t4_reread_miss", 32'(hit), 32'd0);
      chk("t4_model_miss", m_miss, 32'd3);

      // Error on word 2 of the refill: worst response returned, line stays invalid.
      inj_addr = 32'h0000_2008;
      inj_resp = 2'b10;
      rd(32'h0000_2000, 3'b000, hit);
      chk("t5_model_rresp", 32'(exp_rresp), 32'd2);
      inj_addr = 32'hFFFF_FFFF;
      rd(32'h0000_2000, 3'b000, hit);
      chk("t5_reread_miss", 32'(hit), 32'd0);

      // Simultaneous read and write: read first, then the held write (which now hits).
      model_read(32'h0000_3000, d, r, hit);
      exp_rdata = d; exp_rresp = r;
      model_write(32'h0000_3004, 32'hDEAD_BEEF, 4'b1100, 2'b00);
      exp_bresp = 2'b00; wr_bresp = 2'b00;
      ar_q.delete(); arprot_q.delete();
      aw_q.delete(); awprot_q.delete(); wd_q.delete(); ws_q.delete();
      @(negedge clk);
      s_araddr = 32'h0000_3000; s_arprot = 3'b000; s_arvalid = 1;
      s_awaddr = 32'h0000_3004; s_awprot = 3'b000; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b1100;
      s_awvalid = 1; s_wvalid = 1;
      wait_ar_accept();
      @(negedge clk);
      s_arvalid = 0;
      finish_read(hit, 32'h0000_3000, 3'b000);
      chk("t6_write_held", 32'(aw_q.size()), 32'd0);
      n = 0;
      #1;
      while (!s_awready && n < 50) begin @(negedge clk); #1; n++; end
      chk("t6_aw_accept", 32'(n < 50), 32'd1);
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      wait_b_and_check(32'h0000_3004, 32'hDEAD_BEEF, 4'b1100, 3'b000);
      rd(32'h0000_3004, 3'b000, hit);
      chk("t6_write_hit_merge", exp_rdata, 32'hDEAD_3004);
      chk("t6_reread_hit", 32'(hit), 32'd1);

      // Reset in the middle of a refill.
      @(negedge clk);
      s_araddr = 32'h0000_4000; s_arvalid = 1;
      wait_ar_accept();
      @(negedge clk);
      s_arvalid = 0;
      n = 0;
      while (!m_rready && n < 100) begin @(negedge clk); n++; end
      chk("t6_reached_refill", 32'(m_rready), 32'd1);
      rstn = 0;
      repeat (2) @(negedge clk);
      chk_reset("midreset");
      model_clear();
      rstn = 1;
      repeat (2) @(negedge clk);
      rd(32'h0000_1004, 3'b000, hit);
      chk("t6_after_reset_miss", 32'(hit), 32'd0);

      // Random traffic over a small address pool to mix hits, evictions and errors.
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 2))
            0: a = 32'h0000_0000;
            1: a = 32'h0000_1000;
            default: a = 32'h1234_5000;
         endcase
         a = a | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) < 6) begin
            if ($urandom_range(0, 5) == 0) begin
               inj_addr = {a[31:4], 4'b0000} + (32'($urandom_range(0, 3)) << 2);
               inj_resp = 2'($urandom_range(1, 3));
            end
            rd(a, 3'($urandom_range(0, 7)), hit);
            inj_addr = 32'hFFFF_FFFF;
         end else begin
            wr(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
